// File: rtl/dequant2.sv
`timescale 1ns/1ps
// dequant2 -- paired-coefficient JPEG dequantizer.
//
// Multiplies each signed 16-bit quantized DCT coefficient of an incoming pair
// by its entry from an internal 8x8 quantization table (32 packed pairs). It
// then emits the two products saturated to signed 16 bits. The stream is a
// two-stage valid/ready pipeline. The table is loaded through a simple write
// port and resets to identity (every entry 1).
//
// Ports:
//   clk_i        system clock, all state on the rising edge
//   rst_ni       asynchronous active-low reset
//   clear_i      synchronous restart: pair index to 0, pipeline flushed,
//                table contents kept
//   qt_we_i      table write strobe
//   qt_addr_i    table pair index for the write
//   qt_dat_i     {q_first, q_second}, both unsigned
//   in_valid_i   input pair valid
//   in_ready_o   input pair accepted when in_valid_i && in_ready_o
//   in_dat_i     {c_first, c_second}, two's complement
//   out_valid_o  output pair valid
//   out_ready_i  downstream accepts when out_valid_o && out_ready_i
//   out_dat_o    {d_first, d_second}, two's complement, saturated
//   out_last_o   high with the pair at block index BLOCK_PAIRS-1
module dequant2 #(
    parameter int unsigned BLOCK_PAIRS = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        qt_we_i,
    input  logic [4:0]  qt_addr_i,
    input  logic [31:0] qt_dat_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_dat_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_dat_o,
    output logic        out_last_o
);

    localparam logic [4:0] LAST_IDX = 5'(BLOCK_PAIRS - 1);

    logic [31:0] qt [BLOCK_PAIRS];
    logic [4:0]  idx;

    logic        s1_valid;
    logic [31:0] s1_coef;
    logic [31:0] s1_q;
    logic        s1_last;

    logic        s2_load;
    logic        s1_load;
    logic        accept;
    logic [31:0] prod_dat;

    // Signed 16-bit coefficient times unsigned 16-bit table entry. The full
    // 34-bit product is clamped to the signed 16-bit range. It is in range
    // only when bits [33:15] are all equal to the sign bit.
    function automatic logic [15:0] sat_mul(input logic [15:0] c,
                                            input logic [15:0] q);
        logic signed [16:0] cs;
        logic signed [16:0] qs;
        logic signed [33:0] p;
        cs = {c[15], c};
        qs = {1'b0, q};
        p  = 34'(cs) * 34'(qs);
        if (!p[33] && (p[32:15] != '0)) begin
            return 16'h7FFF;
        end else if (p[33] && (p[32:15] != '1)) begin
            return 16'h8000;
        end else begin
            return p[15:0];
        end
    endfunction

    // S2 takes a new value whenever its current content is absent or being
    // consumed. S1 moves whenever it is empty or drains into S2.
    assign s2_load    = !out_valid_o || out_ready_i;
    assign s1_load    = !s1_valid || s2_load;
    assign in_ready_o = !clear_i && s1_load;
    assign accept     = in_valid_i && in_ready_o;

    // The table is read through a register at the accepting edge, so a
    // same-edge write to the same address is not yet visible. Reads therefore
    // see the old value (read-before-write).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < BLOCK_PAIRS; i++) begin
                qt[i] <= 32'h0001_0001;
            end
        end else if (qt_we_i) begin
            qt[qt_addr_i] <= qt_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx <= '0;
        end else if (clear_i) begin
            idx <= '0;
        end else if (accept) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 5'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_coef  <= '0;
            s1_q     <= '0;
            s1_last  <= 1'b0;
        end else if (clear_i) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_coef <= in_dat_i;
                s1_q    <= qt[idx];
                s1_last <= (idx == LAST_IDX);
            end
        end
    end

    always_comb begin
        prod_dat = {sat_mul(s1_coef[31:16], s1_q[31:16]),
                    sat_mul(s1_coef[15:0],  s1_q[15:0])};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_dat_o   <= '0;
            out_last_o  <= 1'b0;
        end else if (clear_i) begin
            out_valid_o <= 1'b0;
        end else if (s2_load) begin
            out_valid_o <= s1_valid;
            if (s1_valid) begin
                out_dat_o  <= prod_dat;
                out_last_o <= s1_last;
            end
        end
    end

endmodule
